// File: rtl/mem_test_sequencer.sv
// RAM speed-test sequencer: settle, fill every address at full rate, then
// read each word back and stream it out one W-bit slice at a time.
module mem_test_sequencer #(
  parameter int unsigned no_of_digits    = 8,
  parameter int unsigned radix_bits      = 3,
  parameter int unsigned address_width   = 14,
  parameter int unsigned max_ram_address = 1024,
  parameter int unsigned burst_index     = 8,
  parameter int unsigned settle_cycles   = 4,
  parameter int unsigned rd_latency      = 2,
  localparam int unsigned word_w         = (no_of_digits + 1) * radix_bits,
  localparam int unsigned ram_w          = word_w * burst_index
) (
  input  logic                     variable_clk_2,
  input  logic                     reset,
  input  logic                     start_signal,
  input  logic                     abort,
  output logic [address_width-1:0] ram_addr,
  output logic                     ram_wren,
  input  logic [ram_w-1:0]         ram_q,
  output logic [word_w-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     transfer_done
);

  localparam int unsigned slice_w  = (burst_index > 1) ? $clog2(burst_index) : 1;
  localparam int unsigned settle_w = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam int unsigned rd_w     = (rd_latency > 0) ? $clog2(rd_latency + 1) : 1;

  localparam logic [address_width-1:0] last_addr   = address_width'(max_ram_address - 1);
  localparam logic [slice_w-1:0]       last_slice  = slice_w'(burst_index - 1);
  localparam logic [settle_w-1:0]      settle_last = settle_w'(settle_cycles - 1);
  localparam logic [rd_w-1:0]          rd_last     = rd_w'(rd_latency);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FILL,
    S_RD_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state;
  logic                start_q;
  logic [settle_w-1:0] settle_cnt;
  logic [rd_w-1:0]     rd_cnt;
  logic [slice_w-1:0]  slice_idx;
  logic [ram_w-1:0]    slice_sr;
  logic                start_edge;

  assign start_edge = start_signal & ~start_q;

  // Sequencer: every output is a register updated here.
  always_ff @(posedge variable_clk_2 or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      start_q       <= 1'b0;
      settle_cnt    <= '0;
      rd_cnt        <= '0;
      slice_idx     <= '0;
      slice_sr      <= '0;
      ram_addr      <= '0;
      ram_wren      <= 1'b0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      busy          <= 1'b0;
      transfer_done <= 1'b0;
    end else begin
      start_q <= start_signal;
      if (abort) begin
        state         <= S_IDLE;
        settle_cnt    <= '0;
        rd_cnt        <= '0;
        slice_idx     <= '0;
        slice_sr      <= '0;
        ram_addr      <= '0;
        ram_wren      <= 1'b0;
        dout          <= '0;
        dout_valid    <= 1'b0;
        busy          <= 1'b0;
        transfer_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge) begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
              ram_addr   <= '0;
              busy       <= 1'b1;
            end
          end

          S_SETTLE: begin
            if (settle_cnt == settle_last) begin
              state    <= S_FILL;
              ram_wren <= 1'b1;
              ram_addr <= '0;
            end else begin
              settle_cnt <= settle_cnt + settle_w'(1);
            end
          end

          S_FILL: begin
            if (ram_addr == last_addr) begin
              state    <= S_RD_WAIT;
              ram_wren <= 1'b0;
              ram_addr <= '0;
              rd_cnt   <= '0;
            end else begin
              ram_addr <= ram_addr + address_width'(1);
            end
          end

          // Address is held until q is valid, then the whole word is captured.
          S_RD_WAIT: begin
            if (rd_cnt == rd_last) begin
              state      <= S_EMIT;
              dout       <= ram_q[word_w-1:0];
              slice_sr   <= ram_q >> word_w;
              dout_valid <= 1'b1;
              slice_idx  <= '0;
            end else begin
              rd_cnt <= rd_cnt + rd_w'(1);
            end
          end

          S_EMIT: begin
            if (dout_ready) begin
              if (slice_idx == last_slice) begin
                dout_valid <= 1'b0;
                dout       <= '0;
                if (ram_addr == last_addr) begin
                  state         <= S_DONE;
                  busy          <= 1'b0;
                  transfer_done <= 1'b1;
                end else begin
                  state    <= S_RD_WAIT;
                  ram_addr <= ram_addr + address_width'(1);
                  rd_cnt   <= '0;
                end
              end else begin
                dout      <= slice_sr[word_w-1:0];
                slice_sr  <= slice_sr >> word_w;
                slice_idx <= slice_idx + slice_w'(1);
              end
            end
          end

          // A new run needs start to drop first, so a held start never restarts.
          S_DONE: begin
            if (!start_signal) begin
              state         <= S_IDLE;
              transfer_done <= 1'b0;
              ram_addr      <= '0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
